pwm_ramp_ctrl: RTL and testbench

PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

---
 rtl/pwm_ramp_ctrl.sv | 96 +++++++++
 tb/tb_pwm_ramp_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_ctrl.sv
// PWM duty ramp controller: steps duty toward a commanded target once per PWM
// period, with a level-sensitive emergency stop that forces duty to zero.
module pwm_ramp_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_target,
  input  logic [3:0] cmd_step,
  input  logic       estop,
  output logic [7:0] duty,
  output logic       period_tick,
  output logic       busy,
  output logic       done,
  output logic [1:0] state
);

  typedef enum logic [1:0] {IDLE = 2'd0, UP = 2'd1, DOWN = 2'd2, FAULT = 2'd3} st_t;

  st_t              st;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       tgt;
  logic [3:0]       stp;
  logic [8:0]       sum, diff;
  logic [7:0]       up_nxt, dn_nxt;
  logic [3:0]       eff_step;

  assign period_tick = &cnt;
  assign cmd_ready   = (st == IDLE) && !estop;
  assign busy        = (st == UP) || (st == DOWN);
  assign state       = st;
  assign eff_step    = (cmd_step == 4'd0) ? 4'd1 : cmd_step;

  // 9-bit arithmetic so the clamp catches both overflow past 255 and underflow below 0
  assign sum    = {1'b0, duty} + {5'b0, stp};
  assign diff   = {1'b0, duty} - {5'b0, stp};
  assign up_nxt = (sum > {1'b0, tgt}) ? tgt : sum[7:0];
  assign dn_nxt = (diff[8] || (diff[7:0] < tgt)) ? tgt : diff[7:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      st   <= IDLE;
      duty <= 8'd0;
      tgt  <= 8'd0;
      stp  <= 4'd0;
      done <= 1'b0;
    end else begin
      cnt  <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      done <= 1'b0;
      if (estop) begin
        duty <= 8'd0;
        st   <= FAULT;
      end else begin
        case (st)
          IDLE: begin
            // acceptance never steps, even on a tick edge; first step is next tick
            if (cmd_valid) begin
              tgt <= cmd_target;
              stp <= eff_step;
              if (cmd_target > duty)      st <= UP;
              else if (cmd_target < duty) st <= DOWN;
              else                        done <= 1'b1;
            end
          end
          UP: begin
            if (period_tick) begin
              duty <= up_nxt;
              if (up_nxt == tgt) begin
                st   <= IDLE;
                done <= 1'b1;
              end
            end
          end
          DOWN: begin
            if (period_tick) begin
              duty <= dn_nxt;
              if (dn_nxt == tgt) begin
                st   <= IDLE;
                done <= 1'b1;
              end
            end
          end
          FAULT: begin
            duty <= 8'd0;
            st   <= IDLE;
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: table of ramp commands with hand-computed
// duty sequences, plus sequences for tick-edge commands, backpressure, estop and reset.
module tb_pwm_ramp_ctrl;

  logic       clk = 1'b0;
  logic       rst, cmd_valid, estop;
  logic       cmd_ready, period_tick, busy, done;
  logic [7:0] cmd_target, duty;
  logic [3:0] cmd_step;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  pwm_ramp_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_target(cmd_target), .cmd_step(cmd_step), .estop(estop),
    .duty(duty), .period_tick(period_tick), .busy(busy), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_cnt++;

  initial begin
    #5ms;
    $display("FAIL timeout: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [7:0] tgt;
    logic [3:0] step;
    logic [1:0] st;
    int         n;
  } vec_t;

  vec_t       vecs [9];
  logic [7:0] seq [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] t, input logic [3:0] s);
    int n = 0;
    cmd_valid  = 1'b1;
    cmd_target = t;
    cmd_step   = s;
    while (!cmd_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("send_ready_timeout", 0, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // waits for the tick, confirms duty held until then, returns just after the tick edge
  task automatic wait_tick(input logic [7:0] prev, output int n);
    n = 0;
    while (!period_tick && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("tick_timeout", 0, 1);
    chk("duty_hold_before_tick", duty, prev);
    @(negedge clk);
  endtask

  initial begin
    int         n, idx, base;
    logic [7:0] prev;

    vecs[0] = '{8'd10,  4'd3,  2'd1, 4};
    vecs[1] = '{8'd0,   4'd15, 2'd2, 1};
    vecs[2] = '{8'd2,   4'd0,  2'd1, 2};
    vecs[3] = '{8'd2,   4'd5,  2'd0, 0};
    vecs[4] = '{8'd250, 4'd15, 2'd1, 17};
    vecs[5] = '{8'd255, 4'd15, 2'd1, 1};
    vecs[6] = '{8'd250, 4'd7,  2'd2, 1};
    vecs[7] = '{8'd3,   4'd15, 2'd2, 17};
    vecs[8] = '{8'd0,   4'd4,  2'd2, 1};
    seq = '{3, 6, 9, 10,
            0,
            1, 2,
            17, 32, 47, 62, 77, 92, 107, 122, 137, 152, 167, 182, 197, 212, 227, 242, 250,
            255,
            250,
            235, 220, 205, 190, 175, 160, 145, 130, 115, 100, 85, 70, 55, 40, 25, 10, 3,
            0};

    rst = 1'b1; estop = 1'b0; cmd_valid = 1'b0; cmd_target = 8'd0; cmd_step = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_duty", duty, 0);
    chk("rst_state", state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tick", period_tick, 0);
    rst = 1'b0;
    chk("rel_ready", cmd_ready, 1);
    n = 0;
    while (!period_tick && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("first_tick_cycle", n, 255);

    idx  = 0;
    prev = 8'd0;
    for (int v = 0; v < 9; v++) begin
      base = done_cnt;
      send(vecs[v].tgt, vecs[v].step);
      chk($sformatf("v%0d_state", v), state, vecs[v].st);
      if (vecs[v].n == 0) begin
        chk($sformatf("v%0d_eq_done", v), done, 1);
        chk($sformatf("v%0d_eq_duty", v), duty, prev);
      end else begin
        chk($sformatf("v%0d_busy", v), busy, 1);
        chk($sformatf("v%0d_ready_busy", v), cmd_ready, 0);
      end
      for (int k = 0; k < vecs[v].n; k++) begin
        wait_tick(prev, n);
        chk($sformatf("v%0d_duty%0d", v, k), duty, seq[idx]);
        prev = seq[idx];
        idx++;
        if (k < vecs[v].n - 1) begin
          chk($sformatf("v%0d_busy%0d", v, k), busy, 1);
          chk($sformatf("v%0d_nodone%0d", v, k), done, 0);
        end else begin
          chk($sformatf("v%0d_end_state", v), state, 0);
          chk($sformatf("v%0d_done", v), done, 1);
          chk($sformatf("v%0d_end_ready", v), cmd_ready, 1);
        end
      end
      @(negedge clk);
      chk($sformatf("v%0d_done_clr", v), done, 0);
      chk($sformatf("v%0d_done_cnt", v), done_cnt, base + 1);
    end

    // command accepted on a tick edge: no step on that tick
    while (!period_tick) @(negedge clk);
    send(8'd5, 4'd2);
    chk("tickcmd_state", state, 1);
    chk("tickcmd_duty", duty, 0);
    wait_tick(8'd0, n);
    chk("tickcmd_wait", n, 255);
    chk("tickcmd_d1", duty, 2);
    wait_tick(8'd2, n);
    chk("tickcmd_d2", duty, 4);
    wait_tick(8'd4, n);
    chk("tickcmd_d3", duty, 5);
    chk("tickcmd_done", done, 1);
    @(negedge clk);

    // backpressure: second command held while busy
    base = done_cnt;
    send(8'd11, 4'd3);
    cmd_valid = 1'b1; cmd_target = 8'd4; cmd_step = 4'd15;
    wait_tick(8'd5, n);
    chk("bp_d1", duty, 8);
    chk("bp_state1", state, 1);
    wait_tick(8'd8, n);
    chk("bp_d2", duty, 11);
    chk("bp_done1", done, 1);
    chk("bp_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp_state2", state, 2);
    wait_tick(8'd11, n);
    chk("bp_d3", duty, 4);
    chk("bp_done2", done, 1);
    repeat (3) @(negedge clk);
    chk("bp_idle", state, 0);
    chk("bp_done_cnt", done_cnt, base + 2);

    // estop mid-ramp at duty 50
    base = done_cnt;
    send(8'd200, 4'd1);
    prev = 8'd4;
    while (duty != 8'd50 && prev < 8'd60) begin
      wait_tick(prev, n);
      prev = prev + 8'd1;
    end
    chk("es_pre_duty", duty, 50);
    repeat (100) @(negedge clk);
    estop = 1'b1;
    chk("es_ready_comb", cmd_ready, 0);
    @(negedge clk);
    chk("es_duty", duty, 0);
    chk("es_state", state, 3);
    chk("es_busy", busy, 0);
    chk("es_done", done, 0);
    repeat (300) @(negedge clk);
    chk("es_hold_duty", duty, 0);
    chk("es_hold_state", state, 3);
    estop = 1'b0;
    @(negedge clk);
    chk("es_rel_state", state, 0);
    chk("es_rel_ready", cmd_ready, 1);
    chk("es_rel_duty", duty, 0);
    chk("es_done_cnt", done_cnt, base);

    // asynchronous reset mid-ramp
    base = done_cnt;
    send(8'd100, 4'd1);
    wait_tick(8'd0, n);
    wait_tick(8'd1, n);
    chk("ar_pre_duty", duty, 2);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("ar_duty", duty, 0);
    chk("ar_state", state, 0);
    chk("ar_busy", busy, 0);
    chk("ar_done", done, 0);
    chk("ar_tick", period_tick, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ar_ready", cmd_ready, 1);
    chk("ar_done_cnt", done_cnt, base);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
